trellis_frame_sequencer: RTL and testbench

Sits directly downstream of the STC frame alignment FIFO stage and feeds the STC trellis.
- Accepts the aligned, decimated sample stream (sample enable, real/imag, interpolate phase) plus the start-of-trellis pulse.
- Frames exactly one trellis block of samples, tags the first and last samples, and registers the data for the trellis.
- Returns a single lastSampleReset pulse upstream after the frame's final sample, so the aligner re-arms for the next frame.

---
 rtl/trellis_frame_sequencer_if.sv | 37 +++
 rtl/trellis_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_trellis_frame_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/trellis_frame_sequencer_if.sv
// trellis_frame_sequencer_if
// Groups the sample stream coming from the frame aligner and the framed
// stream going to the trellis.
//   slave  : the sequencer's view. It receives startOfTrellis, sampleEn,
//            interpolateIn and dinReal/dinImag, and drives dout*, the
//            frame tags, lastSampleReset, frameActive, sampleIndex and
//            overrun.
//   master : the aligner/trellis-side view, with every direction reversed.
interface trellis_frame_sequencer_if;
    logic               startOfTrellis;
    logic               sampleEn;
    logic               interpolateIn;
    logic signed [17:0] dinReal;
    logic signed [17:0] dinImag;
    logic signed [17:0] doutReal;
    logic signed [17:0] doutImag;
    logic               doutValid;
    logic               interpolateOut;
    logic               firstSample;
    logic               lastSample;
    logic               lastSampleReset;
    logic               frameActive;
    logic [14:0]        sampleIndex;
    logic               overrun;

    modport slave (
        input  startOfTrellis, sampleEn, interpolateIn, dinReal, dinImag,
        output doutReal, doutImag, doutValid, interpolateOut, firstSample,
               lastSample, lastSampleReset, frameActive, sampleIndex, overrun
    );

    modport master (
        output startOfTrellis, sampleEn, interpolateIn, dinReal, dinImag,
        input  doutReal, doutImag, doutValid, interpolateOut, firstSample,
               lastSample, lastSampleReset, frameActive, sampleIndex, overrun
    );
endinterface

// File: rtl/trellis_frame_sequencer.sv
// trellis_frame_sequencer
// Frames one trellis block of FRAME_SAMPLES samples from the aligned sample
// stream. It tags the first and last samples, registers the data for the
// trellis, and returns a single lastSampleReset pulse FLUSH_CLKS enabled
// cycles after the last sample so the aligner re-arms.
// Ports:
//   clk2x - processing clock
//   reset - synchronous, active-high reset
//   clkEn - global clock enable; every register updates only when it is high
//   bus   - trellis_frame_sequencer_if.slave (aligner input stream and
//           trellis output stream)
//
// state | meaning
// IDLE  | waiting for startOfTrellis; incoming samples are dropped
// ARM   | frame accepted; the next sampleEn is sample 0
// RUN   | passing samples 1..FRAME_SAMPLES-1
// FLUSH | trellis drain; flushCnt counts down to the lastSampleReset pulse
module trellis_frame_sequencer #(
    parameter int FRAME_SAMPLES = 6656,
    parameter int FLUSH_CLKS    = 8
) (
    input  logic                       clk2x,
    input  logic                       reset,
    input  logic                       clkEn,
    trellis_frame_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, FLUSH} state_t;

    localparam logic [14:0] LAST_IDX   = 15'(FRAME_SAMPLES - 1);
    localparam logic [7:0]  FLUSH_INIT = 8'(FLUSH_CLKS - 1);

    state_t      state, stateNext;
    logic [14:0] count, countNext;
    logic [7:0]  flushCnt, flushNext;
    logic        take;
    logic        firstNext;
    logic        lastNext;
    logic        lsrNext;
    logic        activeNext;
    logic        overrunNext;

    always_ff @(posedge clk2x) begin
        if (reset) begin
            state               <= IDLE;
            count               <= '0;
            flushCnt            <= '0;
            bus.doutReal        <= '0;
            bus.doutImag        <= '0;
            bus.doutValid       <= 1'b0;
            bus.interpolateOut  <= 1'b0;
            bus.firstSample     <= 1'b0;
            bus.lastSample      <= 1'b0;
            bus.lastSampleReset <= 1'b0;
            bus.frameActive     <= 1'b0;
            bus.sampleIndex     <= '0;
            bus.overrun         <= 1'b0;
        end else if (clkEn) begin
            state               <= stateNext;
            count               <= countNext;
            flushCnt            <= flushNext;
            bus.doutValid       <= take;
            bus.firstSample     <= firstNext;
            bus.lastSample      <= lastNext;
            bus.lastSampleReset <= lsrNext;
            bus.frameActive     <= activeNext;
            bus.overrun         <= overrunNext;
            if (take) begin
                bus.doutReal       <= bus.dinReal;
                bus.doutImag       <= bus.dinImag;
                bus.interpolateOut <= bus.interpolateIn;
                bus.sampleIndex    <= count;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        countNext   = count;
        flushNext   = flushCnt;
        take        = 1'b0;
        firstNext   = 1'b0;
        lastNext    = 1'b0;
        lsrNext     = 1'b0;
        activeNext  = bus.frameActive;
        overrunNext = bus.overrun;

        case (state)
            IDLE: begin
                // A sample coincident with startOfTrellis is not part of the
                // frame; sample 0 is the next sampleEn.
                if (bus.startOfTrellis) begin
                    stateNext  = ARM;
                    countNext  = '0;
                    activeNext = 1'b1;
                end
            end
            ARM: begin
                if (bus.sampleEn) begin
                    take      = 1'b1;
                    firstNext = 1'b1;
                    countNext = 15'd1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (bus.sampleEn) begin
                    take = 1'b1;
                    if (count == LAST_IDX) begin
                        lastNext  = 1'b1;
                        flushNext = FLUSH_INIT;
                        stateNext = FLUSH;
                    end else begin
                        countNext = count + 15'd1;
                    end
                end
            end
            FLUSH: begin
                if (flushCnt == 8'd0) begin
                    lsrNext    = 1'b1;
                    activeNext = 1'b0;
                    stateNext  = IDLE;
                end else begin
                    flushNext = flushCnt - 8'd1;
                end
            end
            default: stateNext = IDLE;
        endcase

        // A new frame request before the current one has finished is an
        // aligner error; it does not disturb sequencing.
        if (bus.startOfTrellis && (state != IDLE))
            overrunNext = 1'b1;
    end

endmodule

// File: tb/tb_trellis_frame_sequencer.sv
// tb_trellis_frame_sequencer
// Directed bench for trellis_frame_sequencer with FRAME_SAMPLES=16 and
// FLUSH_CLKS=4. Expected values are computed by hand from the sample
// number k and the test setup.
module tb_trellis_frame_sequencer;

    localparam int FRAMES = 16;
    localparam int FLUSH  = 4;

    logic clk2x;
    logic reset;
    logic clkEn;
    bit   gateMode;
    bit   overrunExp;

    int checkCount;
    int failCount;

    trellis_frame_sequencer_if bus ();

    trellis_frame_sequencer #(
        .FRAME_SAMPLES (FRAMES),
        .FLUSH_CLKS    (FLUSH)
    ) dut (
        .clk2x (clk2x),
        .reset (reset),
        .clkEn (clkEn),
        .bus   (bus)
    );

    initial clk2x = 1'b0;
    always #5 clk2x = ~clk2x;

    task automatic checkVal(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One enabled cycle. In gate mode it is followed by one clkEn=0 cycle,
    // so every check made after cyc shows the outputs holding.
    task automatic cyc();
        clkEn = 1'b1;
        @(posedge clk2x);
        #1;
        if (gateMode) begin
            clkEn = 1'b0;
            @(posedge clk2x);
            #1;
            clkEn = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bus.sampleEn       = 1'b0;
        bus.startOfTrellis = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic checkResetState();
        checkVal("rst doutValid",   int'(bus.doutValid), 0);
        checkVal("rst doutReal",    int'(bus.doutReal), 0);
        checkVal("rst doutImag",    int'(bus.doutImag), 0);
        checkVal("rst interpOut",   int'(bus.interpolateOut), 0);
        checkVal("rst first",       int'(bus.firstSample), 0);
        checkVal("rst last",        int'(bus.lastSample), 0);
        checkVal("rst lsr",         int'(bus.lastSampleReset), 0);
        checkVal("rst frameActive", int'(bus.frameActive), 0);
        checkVal("rst sampleIndex", int'(bus.sampleIndex), 0);
        checkVal("rst overrun",     int'(bus.overrun), 0);
    endtask

    // Runs one whole frame: optional startOfTrellis, 16 samples of value
    // base+k / -(base+k), and the flush with its lastSampleReset pulse.
    // overrunAt >= 0 re-pulses startOfTrellis together with that sample.
    task automatic runFrame(input int base, input bit doStart, input int overrunAt);
        if (doStart) begin
            bus.sampleEn       = 1'b0;
            bus.startOfTrellis = 1'b1;
            cyc();
            checkVal("start frameActive", int'(bus.frameActive), 1);
            checkVal("start doutValid",   int'(bus.doutValid), 0);
            bus.startOfTrellis = 1'b0;
        end
        for (int k = 0; k < FRAMES; k++) begin
            bus.sampleEn       = 1'b1;
            bus.dinReal        = 18'(base + k);
            bus.dinImag        = 18'(-(base + k));
            bus.interpolateIn  = ((k % 4) == 2);
            bus.startOfTrellis = (k == overrunAt);
            cyc();
            if (k == overrunAt) overrunExp = 1'b1;
            checkVal("doutValid",   int'(bus.doutValid), 1);
            checkVal("doutReal",    int'($signed(bus.doutReal)), base + k);
            checkVal("doutImag",    int'($signed(bus.doutImag)), -(base + k));
            checkVal("sampleIndex", int'(bus.sampleIndex), k);
            checkVal("firstSample", int'(bus.firstSample), int'(k == 0));
            checkVal("lastSample",  int'(bus.lastSample), int'(k == FRAMES - 1));
            checkVal("interpOut",   int'(bus.interpolateOut), int'((k % 4) == 2));
            checkVal("frameActive", int'(bus.frameActive), 1);
            checkVal("overrun",     int'(bus.overrun), int'(overrunExp));
            checkVal("lsr in frame", int'(bus.lastSampleReset), 0);
        end
        bus.sampleEn       = 1'b0;
        bus.startOfTrellis = 1'b0;
        for (int j = 1; j <= FLUSH + 1; j++) begin
            cyc();
            checkVal("flush doutValid",   int'(bus.doutValid), 0);
            checkVal("flush doutReal",    int'($signed(bus.doutReal)), base + FRAMES - 1);
            checkVal("flush interpOut",   int'(bus.interpolateOut), int'(((FRAMES - 1) % 4) == 2));
            checkVal("flush lsr",         int'(bus.lastSampleReset), int'(j == FLUSH));
            checkVal("flush frameActive", int'(bus.frameActive), int'(j < FLUSH));
        end
    endtask

    initial begin
        checkCount         = 0;
        failCount          = 0;
        gateMode           = 1'b0;
        overrunExp         = 1'b0;
        clkEn              = 1'b1;
        reset              = 1'b1;
        bus.startOfTrellis = 1'b0;
        bus.sampleEn       = 1'b0;
        bus.interpolateIn  = 1'b0;
        bus.dinReal        = '0;
        bus.dinImag        = '0;

        cyc();
        cyc();
        checkResetState();
        reset = 1'b0;
        idle(2);

        // Basic frame, clkEn held high.
        runFrame(0, 1'b1, -1);
        idle(2);

        // Same frame with clkEn alternating 1/0.
        gateMode = 1'b1;
        runFrame(0, 1'b1, -1);
        gateMode = 1'b0;
        idle(2);

        // Samples before startOfTrellis, and the coincident one, are dropped.
        for (int i = 0; i < 5; i++) begin
            bus.sampleEn = 1'b1;
            bus.dinReal  = 18'(50 + i);
            bus.dinImag  = 18'(-(50 + i));
            cyc();
            checkVal("pre doutValid", int'(bus.doutValid), 0);
            checkVal("pre doutReal held", int'($signed(bus.doutReal)), FRAMES - 1);
        end
        bus.sampleEn       = 1'b1;
        bus.startOfTrellis = 1'b1;
        bus.dinReal        = 18'd99;
        bus.dinImag        = -18'sd99;
        cyc();
        checkVal("coinc doutValid",   int'(bus.doutValid), 0);
        checkVal("coinc frameActive", int'(bus.frameActive), 1);
        checkVal("coinc doutReal",    int'($signed(bus.doutReal)), FRAMES - 1);
        bus.startOfTrellis = 1'b0;
        runFrame(200, 1'b0, -1);
        idle(2);

        // startOfTrellis re-pulsed at sample 7: frame completes, overrun sticks.
        runFrame(300, 1'b1, 7);
        idle(3);
        checkVal("overrun sticky", int'(bus.overrun), 1);

        // Reset at sample 10 abandons the frame with no lastSampleReset.
        bus.startOfTrellis = 1'b1;
        bus.sampleEn       = 1'b0;
        cyc();
        bus.startOfTrellis = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.sampleEn = 1'b1;
            bus.dinReal  = 18'(400 + k);
            bus.dinImag  = 18'(-(400 + k));
            cyc();
            checkVal("pre-rst sampleIndex", int'(bus.sampleIndex), k);
        end
        reset = 1'b1;
        cyc();
        checkResetState();
        overrunExp = 1'b0;
        reset      = 1'b0;
        for (int i = 0; i < FLUSH + 4; i++) begin
            bus.sampleEn = 1'b1;
            cyc();
            checkVal("post-rst lsr",         int'(bus.lastSampleReset), 0);
            checkVal("post-rst frameActive", int'(bus.frameActive), 0);
            checkVal("post-rst doutValid",   int'(bus.doutValid), 0);
        end
        bus.sampleEn = 1'b0;
        runFrame(500, 1'b1, -1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
